// File: rtl/prg_bridge_pkg.sv
// Shared types and sizing for the monitor-to-program-RAM bridge.
// Imported by the bridge top and its synchronizer.
package prg_bridge_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int HALT_DEF    = 4;
  localparam int RELEASE_DEF = 4;

  typedef enum logic [2:0] {
    S_RUN,
    S_HALT,
    S_PIDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_RELEASE
  } state_t;

  // Counter runs 0..max-1, so it needs clog2(max) bits, at least one.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int CNT_W_DEF = cnt_w(HALT_DEF, RELEASE_DEF);

endpackage

// File: rtl/prg_mem_bridge_sync_edge.sv
// Multi-flop synchronizer with a registered previous value.
// Exposes the synced level and a one-cycle rising-edge pulse.
module sync_edge
  import prg_bridge_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the async input in and remember last synced value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/prg_mem_bridge.sv
// Monitor PIO to program RAM bridge with CPU/monitor arbitration.
// The CPU is held in reset whenever the monitor owns the RAM.
module prg_mem_bridge
  import prg_bridge_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int HALT_CYCLES    = HALT_DEF,
  parameter int RELEASE_CYCLES = RELEASE_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] prg_ma,
  input  logic [DATA_W-1:0] prg_wd,
  output logic [DATA_W-1:0] prg_rd,
  input  logic              prg_clock,
  input  logic              prg_we,
  input  logic              reset_1,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_reset_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              overrun
);

  localparam int CNT_W = cnt_w(HALT_CYCLES, RELEASE_CYCLES);
  localparam logic [CNT_W-1:0] HALT_LAST =
    CNT_W'(HALT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST =
    CNT_W'(RELEASE_CYCLES - 1);

  state_t            r_state;
  state_t            w_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] r_ma;
  logic [DATA_W-1:0] r_wd;
  logic [DATA_W-1:0] r_rd;
  logic              r_ovr;

  logic w_edge;
  logic w_unused_clk_lvl;
  logic w_we;
  logic w_unused_we_rise;
  logic w_rst1;
  logic w_rst1_rise;
  logic w_latch;
  logic w_capture;
  logic w_ovr_set;
  logic w_own;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_d     (prg_clock),
    .o_level (w_unused_clk_lvl),
    .o_rise  (w_edge)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_we (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_d     (prg_we),
    .o_level (w_we),
    .o_rise  (w_unused_we_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rst1 (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_d     (reset_1),
    .o_level (w_rst1),
    .o_rise  (w_rst1_rise)
  );

  // Next-state, counter and strobe decode for the mode FSM.
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_latch   = 1'b0;
    w_capture = 1'b0;
    w_ovr_set = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (w_rst1) begin
          w_nxt     = S_HALT;
          w_cnt_nxt = '0;
        end
      end
      S_HALT: begin
        if (r_cnt == HALT_LAST) begin
          w_nxt     = S_PIDLE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_PIDLE: begin
        if (w_edge) begin
          w_latch = 1'b1;
          w_nxt   = w_we ? S_WRITE : S_READ;
        end else if (!w_rst1) begin
          w_nxt     = S_RELEASE;
          w_cnt_nxt = '0;
        end
      end
      S_WRITE: begin
        w_nxt     = S_READ;
        w_ovr_set = w_edge;
      end
      S_READ: begin
        w_nxt     = S_CAPTURE;
        w_ovr_set = w_edge;
      end
      S_CAPTURE: begin
        w_nxt     = S_PIDLE;
        w_capture = 1'b1;
        w_ovr_set = w_edge;
      end
      S_RELEASE: begin
        if (w_rst1_rise) begin
          w_nxt     = S_HALT;
          w_cnt_nxt = '0;
        end else if (r_cnt == REL_LAST) begin
          w_nxt     = S_RUN;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_nxt     = S_RELEASE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // State and counter registers; reset parks in RELEASE.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= S_RELEASE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latch monitor address/data on the accepted strobe edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_ma <= '0;
      r_wd <= '0;
    end else if (w_latch) begin
      r_ma <= prg_ma;
      r_wd <= prg_wd;
    end
  end

  // Read-back capture and sticky overrun flag.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rd  <= '0;
      r_ovr <= 1'b0;
    end else begin
      if (w_capture) r_rd <= mem_rdata;
      if (w_ovr_set) r_ovr <= 1'b1;
    end
  end

  assign w_own = (r_state == S_PIDLE)
              || (r_state == S_WRITE)
              || (r_state == S_READ)
              || (r_state == S_CAPTURE);

  assign mem_addr    = w_own ? r_ma : cpu_addr;
  assign mem_wdata   = r_wd;
  assign mem_we      = (r_state == S_WRITE);
  assign cpu_reset_n = (r_state == S_RUN);
  assign cpu_rdata   = mem_rdata;
  assign prg_rd      = r_rd;
  assign overrun     = r_ovr;

endmodule

// File: tb/tb_prg_mem_bridge.sv
// Directed bench for prg_mem_bridge with a behavioural 256x8 RAM.
// Strobe timing is counted from the synced edge cycle E.
module tb_prg_mem_bridge;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [7:0] prg_ma;
  logic [7:0] prg_wd;
  logic [7:0] prg_rd;
  logic       prg_clock;
  logic       prg_we;
  logic       reset_1;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_rdata;
  logic       cpu_reset_n;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       overrun;

  logic [7:0] ram [256];
  logic       tb_pre;
  int         wcount = 0;
  int         w0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk_clk = ~clk_clk;

  prg_mem_bridge dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .prg_ma        (prg_ma),
    .prg_wd        (prg_wd),
    .prg_rd        (prg_rd),
    .prg_clock     (prg_clock),
    .prg_we        (prg_we),
    .reset_1       (reset_1),
    .cpu_addr      (cpu_addr),
    .cpu_rdata     (cpu_rdata),
    .cpu_reset_n   (cpu_reset_n),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata),
    .overrun       (overrun)
  );

  // Synchronous RAM, one-cycle read latency, write counter.
  always @(posedge clk_clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wcount <= wcount + 1;
    end else if (tb_pre) begin
      ram[8'h20] <= 8'h5A;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  // Raise the strobe and advance to the synced edge cycle E.
  task automatic strobe(input logic [7:0] ma,
                        input logic [7:0] wd,
                        input logic we);
    prg_ma    = ma;
    prg_wd    = wd;
    prg_we    = we;
    prg_clock = 1'b1;
    tick(2);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_reset_n = 1'b0;
    reset_1   = 1'b0;
    prg_clock = 1'b0;
    prg_we    = 1'b0;
    prg_ma    = 8'h00;
    prg_wd    = 8'h00;
    cpu_addr  = 8'h3C;
    tb_pre    = 1'b0;
    #12;
    check("rst_cpu_reset_n", cpu_reset_n, 0);
    check("rst_prg_rd", prg_rd, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_overrun", overrun, 0);
    check("rst_mem_addr", mem_addr, 8'h3C);
    tb_pre = 1'b1;
    tick();
    tb_pre = 1'b0;

    // 1: reset release
    reset_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("rel_cpu_reset_n", cpu_reset_n, 0);
      check("rel_mem_addr", mem_addr, 8'h3C);
      tick();
    end
    check("run_cpu_reset_n", cpu_reset_n, 1);
    check("run_mem_addr", mem_addr, 8'h3C);

    // 2: enter program mode and write
    reset_1 = 1'b1;
    tick(2);
    check("req_still_run", cpu_reset_n, 1);
    tick();
    check("halt_cpu_reset_n", cpu_reset_n, 0);
    tick(5);
    strobe(8'h10, 8'hA5, 1'b1);
    check("wr_e_mem_we", mem_we, 0);
    prg_clock = 1'b0;
    tick();
    check("wr_e1_mem_we", mem_we, 1);
    check("wr_e1_addr", mem_addr, 8'h10);
    check("wr_e1_data", mem_wdata, 8'hA5);
    tick();
    check("wr_e2_mem_we", mem_we, 0);
    check("wr_e2_addr", mem_addr, 8'h10);
    tick(2);
    check("wr_e4_prg_rd", prg_rd, 8'hA5);
    check("wr_count", wcount, 1);
    check("wr_ram", ram[8'h10], 8'hA5);

    // 3: read-only
    tick(4);
    w0 = wcount;
    strobe(8'h20, 8'h00, 1'b0);
    prg_clock = 1'b0;
    tick();
    check("rd_e1_mem_we", mem_we, 0);
    check("rd_e1_addr", mem_addr, 8'h20);
    tick();
    check("rd_e2_hold", prg_rd, 8'hA5);
    tick();
    check("rd_e3_prg_rd", prg_rd, 8'h5A);
    check("rd_cpu_reset_n", cpu_reset_n, 0);
    check("rd_no_write", wcount, w0);

    // 4: overrun
    tick(4);
    w0 = wcount;
    prg_ma    = 8'h30;
    prg_wd    = 8'hC3;
    prg_we    = 1'b1;
    prg_clock = 1'b1;
    tick();
    prg_clock = 1'b0;
    tick();
    prg_clock = 1'b1;
    tick();
    check("ovr_e1_mem_we", mem_we, 1);
    check("ovr_e1_flag", overrun, 0);
    tick();
    prg_clock = 1'b0;
    tick();
    check("ovr_flag", overrun, 1);
    tick(6);
    check("ovr_one_write", wcount, w0 + 1);
    check("ovr_ram", ram[8'h30], 8'hC3);
    check("ovr_prg_rd", prg_rd, 8'hC3);
    check("ovr_sticky", overrun, 1);

    // 5: exit coincident with a write edge
    reset_1 = 1'b0;
    strobe(8'h44, 8'h99, 1'b1);
    prg_clock = 1'b0;
    cpu_addr  = 8'h81;
    tick();
    check("ex_e1_mem_we", mem_we, 1);
    check("ex_e1_addr", mem_addr, 8'h44);
    tick(3);
    check("ex_e4_prg_rd", prg_rd, 8'h99);
    check("ex_e4_cpu_rst", cpu_reset_n, 0);
    tick(4);
    check("ex_e8_cpu_rst", cpu_reset_n, 0);
    tick();
    check("ex_e9_cpu_rst", cpu_reset_n, 1);
    check("ex_e9_addr", mem_addr, 8'h81);
    check("ex_rd_hold", prg_rd, 8'h99);

    // 6: async reset during WRITE
    reset_1 = 1'b1;
    tick(10);
    check("ar_pidle_rst", cpu_reset_n, 0);
    strobe(8'h55, 8'h77, 1'b1);
    prg_clock = 1'b0;
    tick();
    check("ar_mem_we_hi", mem_we, 1);
    #2;
    reset_reset_n = 1'b0;
    #1;
    check("ar_mem_we", mem_we, 0);
    check("ar_prg_rd", prg_rd, 0);
    check("ar_cpu_rst", cpu_reset_n, 0);
    check("ar_overrun", overrun, 0);
    check("ar_wdata", mem_wdata, 0);
    tick();
    reset_reset_n = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prg_mem_bridge.md
Name: prg_mem_bridge

Overview:
- Sits directly downstream of the monitor system's prg_* PIO exports.
- Turns the monitor's software-driven strobes into single-cycle write/read cycles on the CPU's 256x8 synchronous program RAM.
- Arbitrates the RAM port between the CPU, in run mode, and the monitor, in program mode.
- Holds the CPU in reset while the monitor owns the memory.

Parameters:
- ADDR_W, 8, program memory address width.
- DATA_W, 8, program memory data width.
- SYNC_STAGES, 2, flip-flop stages on prg_clock, prg_we and reset_1; minimum 2.
- HALT_CYCLES, 4, cycles cpu_reset_n is held low before monitor access is granted.
- RELEASE_CYCLES, 4, cycles cpu_reset_n stays low after program mode is exited.

Ports:
- clk_clk  in  1  system clock, shared with the monitor.
- reset_reset_n  in  1  asynchronous, active-low reset.
- prg_ma  in  ADDR_W  monitor address.
- prg_wd  in  DATA_W  monitor write data.
- prg_rd  out  DATA_W  read-back data to the monitor.
- prg_clock  in  1  transaction strobe; the rising edge is significant.
- prg_we  in  1  1 = write+verify, 0 = read only.
- reset_1  in  1  1 = program mode request.
- cpu_addr  in  ADDR_W  CPU fetch address.
- cpu_rdata  out  DATA_W  fetch data; always equals mem_rdata.
- cpu_reset_n  out  1  active-low CPU reset.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data; 1-cycle latency after mem_addr.
- overrun  out  1  sticky flag: a strobe edge was dropped.

Behaviour:
- Reset, while reset_reset_n is low:
  - state = RELEASE with counter 0.
  - prg_rd = 0, cpu_reset_n = 0, mem_we = 0, mem_wdata = 0, overrun = 0.
  - Latched address and data registers = 0.
  - Synchronizers cleared to 0.
- Synchronization:
  - prg_clock, prg_we and reset_1 pass through SYNC_STAGES flops.
  - Edge E is the cycle the synced prg_clock is 1 and its previous value was 0.
  - prg_ma and prg_wd are sampled in cycle E; the monitor holds them stable around the strobe.
- States:
  - RUN:
    - mem_addr = cpu_addr, mem_we = 0, cpu_reset_n = 1.
    - Edges are ignored; they do not set overrun.
    - Synced reset_1 = 1 -> HALT, counter cleared.
  - HALT:
    - cpu_reset_n = 0, mem_addr = cpu_addr.
    - After HALT_CYCLES cycles -> PIDLE.
    - Edges are ignored.
  - PIDLE:
    - cpu_reset_n = 0, mem_addr = latched ma.
    - On edge E: latch ma, wd and the synced we. Next state is WRITE if we = 1, else READ.
    - Otherwise, if synced reset_1 = 0 -> RELEASE.
    - An edge and reset_1 falling in the same cycle: the edge wins. The transaction completes first, and the exit is taken from PIDLE afterwards.
  - WRITE (1 cycle): mem_addr = ma, mem_wdata = wd, mem_we = 1 -> READ.
  - READ (1 cycle): mem_addr = ma, mem_we = 0 -> CAPTURE.
  - CAPTURE (1 cycle): prg_rd <= mem_rdata -> PIDLE.
  - RELEASE:
    - cpu_reset_n = 0, mem_addr = cpu_addr.
    - After RELEASE_CYCLES cycles -> RUN.
    - If reset_1 rises during RELEASE -> HALT; the counter restarts.
- Latency, counted from edge E:
  - Write transaction: mem_we high in E+1; prg_rd holds the read-back of the written byte from E+4.
  - Read transaction: prg_rd valid from E+3.
  - Add SYNC_STAGES cycles when counting from the prg_clock pin.
- Overrun:
  - An edge detected in WRITE, READ or CAPTURE is dropped and sets overrun.
  - overrun clears only on reset.
- prg_rd holds its value between transactions and across mode changes.
- Address wrap-around is not applicable; each transaction is a single address.
- The address mux is registered-free (combinational); mem_we is driven from the state register only.

Decomposition:
- Package prg_bridge_pkg holds:
  - state enum: RUN, HALT, PIDLE, WRITE, READ, CAPTURE, RELEASE.
  - default ADDR_W and DATA_W.
  - counter width, derived from max(HALT_CYCLES, RELEASE_CYCLES).
- Sub-module sync_edge: SYNC_STAGES-flop synchronizer with a registered previous value.
  - Outputs: level, rise.
  - Instantiated for prg_clock, prg_we and reset_1.

Test Plan:
1. Reset release:
   - Stimulus: deassert reset_reset_n with reset_1 = 0.
   - Required: cpu_reset_n = 0 for RELEASE_CYCLES, then 1; mem_addr tracks cpu_addr = 0x3C.
2. Enter program mode and write:
   - Stimulus: reset_1 = 1; after HALT, prg_ma = 0x10, prg_wd = 0xA5, prg_we = 1, pulse prg_clock.
   - Required: exactly one mem_we cycle with addr 0x10 and data 0xA5; prg_rd = 0xA5 at E+4.
3. Read-only:
   - Stimulus: RAM[0x20] preloaded to 0x5A; prg_we = 0, prg_ma = 0x20, strobe.
   - Required: no mem_we; prg_rd = 0x5A at E+3; cpu_reset_n stays 0.
4. Overrun:
   - Stimulus: second prg_clock edge arrives two cycles after the first (synced).
   - Required: second edge ignored; overrun = 1; only one write to RAM.
5. Exit during a transaction:
   - Stimulus: drop reset_1 in the same cycle as a write edge.
   - Required: write completes and prg_rd is updated; then RELEASE; cpu_reset_n = 1 after RELEASE_CYCLES.
6. Async reset mid-WRITE:
   - Stimulus: reset_reset_n pulsed low while mem_we = 1.
   - Required: mem_we = 0, prg_rd = 0 and cpu_reset_n = 0 immediately, without waiting for a clock edge.
